// File: rtl/shifter_arbiter.sv
// Round-robin share of one 48-bit barrel shifter between two requesters.
// Optional sticky output enabled by defining SHIFTER_ARB_STICKY_EN.
module shifter_arbiter #(
    parameter int WIDTH     = 48,
    parameter int AMT_W     = 6,
    parameter int INIT_PRIO = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_data,
    input  logic [AMT_W-1:0] i_req0_amt,
    input  logic             i_req0_left,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_data,
    input  logic [AMT_W-1:0] i_req1_amt,
    input  logic             i_req1_left,
    output logic             o_req1_ready,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_id,
    output logic             o_rsp_sticky,
    input  logic             i_rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             g0;
    logic             g1;
    logic [WIDTH-1:0] op_data;
    logic [AMT_W-1:0] op_amt;
    logic             op_left;
    logic             op_id;
    logic [WIDTH-1:0] sh_data;

    // Ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nxt = state;
        g0        = 1'b0;
        g1        = 1'b0;
        case (state)
            IDLE: begin
                if (!i_rst) begin
                    if (i_req0_valid && (!i_req1_valid || !ptr)) begin
                        g0 = 1'b1;
                    end else if (i_req1_valid) begin
                        g1 = 1'b1;
                    end
                end
                if (g0 || g1) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: state_nxt = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_req0_ready = g0;
    assign o_req1_ready = g1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        sh_data = '0;
        if (op_amt < MAX_AMT) begin
            sh_data = op_left ? (op_data << op_amt) : (op_data >> op_amt);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr         <= 1'(INIT_PRIO);
            op_data     <= '0;
            op_amt      <= '0;
            op_left     <= 1'b0;
            op_id       <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= 1'b0;
        end else begin
            if (g0 || g1) begin
                op_data <= g0 ? i_req0_data : i_req1_data;
                op_amt  <= g0 ? i_req0_amt : i_req1_amt;
                op_left <= g0 ? i_req0_left : i_req1_left;
                op_id   <= g1;
                // Pointer always moves to the requester that lost or was absent.
                ptr     <= g0;
            end
            if (state == SHIFT) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= sh_data;
                o_rsp_id    <= op_id;
            end else if (state == RESP && i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFTER_ARB_STICKY_EN
    logic [WIDTH-1:0] lost_mask;
    logic             sh_sticky;

    // Amounts of WIDTH or more shift the all-ones mask fully out.
    always_comb begin
        lost_mask = ~({WIDTH{1'b1}} << op_amt);
        sh_sticky = !op_left && (|(op_data & lost_mask));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_sticky <= 1'b0;
        end else if (state == SHIFT) begin
            o_rsp_sticky <= sh_sticky;
        end
    end
`else
    assign o_rsp_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed-vector bench for shifter_arbiter.
module tb_shifter_arbiter;

`ifdef SHIFTER_ARB_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    localparam logic [47:0] ONES = {48{1'b1}};

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, l0, l1, r0, r1;
    logic [47:0] d0, d1;
    logic [5:0]  a0, a1;
    logic        rsp_valid, rsp_id, rsp_sticky, rsp_ready;
    logic [47:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shifter_arbiter #(.INIT_PRIO(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .i_req0_data  (d0),
        .i_req0_amt   (a0),
        .i_req0_left  (l0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_data  (d1),
        .i_req1_amt   (a1),
        .i_req1_left  (l1),
        .o_req1_ready (r1),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .o_rsp_sticky (rsp_sticky),
        .i_rsp_ready  (rsp_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic id,
                         input logic [47:0] d, input logic [5:0] a,
                         input logic l, input logic [47:0] ed,
                         input logic es);
        @(negedge clk);
        if (id) begin
            v1 = 1'b1; d1 = d; a1 = a; l1 = l;
        end else begin
            v0 = 1'b1; d0 = d; a0 = a; l0 = l;
        end
        #1;
        check({tag, "_rdy"}, {63'd0, id ? r1 : r0}, 64'd1);
        check({tag, "_rdyx"}, {63'd0, id ? r0 : r1}, 64'd0);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        check({tag, "_v_shift"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rdy_shift"}, {62'd0, r1, r0}, 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, ed});
        check({tag, "_id"}, {63'd0, rsp_id}, {63'd0, id});
        check({tag, "_sticky"}, {63'd0, rsp_sticky}, {63'd0, es});
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_v_done"}, {63'd0, rsp_valid}, 64'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v0 = 0; v1 = 0; l0 = 0; l1 = 0;
        d0 = '0; d1 = '0; a0 = '0; a1 = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        v0 = 1'b1;
        #1;
        check("rst_rdy0", {63'd0, r0}, 64'd0);
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_data", {16'd0, rsp_data}, 64'd0);
        check("rst_id", {63'd0, rsp_id}, 64'd0);
        check("rst_sticky", {63'd0, rsp_sticky}, 64'd0);
        v0 = 1'b0;
        rst = 1'b0;

        do_op("l4", 0, 48'h0000_0000_00F0, 6'd4, 1, 48'h0000_0000_0F00, 0);
        do_op("r1", 1, 48'h8000_0000_0001, 6'd1, 0, 48'h4000_0000_0000, STK);
        do_op("l48", 0, ONES, 6'd48, 1, 48'h0, 0);
        do_op("r63", 1, ONES, 6'd63, 0, 48'h0, STK);
        do_op("l63", 0, ONES, 6'd63, 1, 48'h0, 0);
        do_op("r48", 1, ONES, 6'd48, 0, 48'h0, STK);
        do_op("l0", 0, 48'h1234_5678_9ABC, 6'd0, 1, 48'h1234_5678_9ABC, 0);
        do_op("r0", 1, 48'hFFFF_0000_FFFF, 6'd0, 0, 48'hFFFF_0000_FFFF, 0);
        do_op("l1msb", 1, 48'h8000_0000_0001, 6'd1, 1, 48'h0000_0000_0002, 0);
        do_op("r4z", 0, 48'h0000_0000_00F0, 6'd4, 0, 48'h0000_0000_000F, 0);
        do_op("r16", 0, 48'hABCD_0000_0000, 6'd16, 0, 48'h0000_ABCD_0000, 0);
        do_op("r47", 1, 48'h8000_0000_0003, 6'd47, 0, 48'h0000_0000_0001, STK);

        // Both requesters always valid: grants alternate 0,1,0,1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = 1'b1; d0 = 48'h1; a0 = 6'd1; l0 = 1'b1;
        v1 = 1'b1; d1 = 48'h4; a1 = 6'd1; l1 = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("alt_r0_%0d", k), {63'd0, r0},
                  {63'd0, (k % 3 == 0) && ((k / 3) % 2 == 0)});
            check($sformatf("alt_r1_%0d", k), {63'd0, r1},
                  {63'd0, (k % 3 == 0) && ((k / 3) % 2 == 1)});
            if (k % 3 == 2) begin
                check($sformatf("alt_v_%0d", k), {63'd0, rsp_valid}, 64'd1);
                check($sformatf("alt_id_%0d", k), {63'd0, rsp_id},
                      {63'd0, ((k / 3) % 2 == 1)});
                check($sformatf("alt_d_%0d", k), {16'd0, rsp_data},
                      ((k / 3) % 2 == 1) ? 64'h2 : 64'h2);
            end
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b0;

        // Stall the consumer with a competing request pending, then reset.
        @(negedge clk);
        v0 = 1'b1; d0 = 48'h0000_0000_00F0; a0 = 6'd4; l0 = 1'b1;
        #1;
        check("hold_acc", {63'd0, r0}, 64'd1);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b1; d1 = 48'h8000_0000_0001; a1 = 6'd1; l1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold_v%0d", k), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("hold_d%0d", k), {16'd0, rsp_data}, 64'hF00);
            check($sformatf("hold_id%0d", k), {63'd0, rsp_id}, 64'd0);
            check($sformatf("hold_rdy%0d", k), {62'd0, r1, r0}, 64'd0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, rsp_valid}, 64'd0);
        check("arst_data", {16'd0, rsp_data}, 64'd0);
        check("arst_id", {63'd0, rsp_id}, 64'd0);
        check("arst_sticky", {63'd0, rsp_sticky}, 64'd0);
        check("arst_rdy", {62'd0, r1, r0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_idle_r1", {63'd0, r1}, 64'd1);
        check("arst_idle_r0", {63'd0, r0}, 64'd0);
        v1 = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
